register_file: RTL and testbench



---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_read_port.sv | 40 ++++
 rtl/register_file.sv | 74 +++++++
 tb/tb_register_file.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg : shared widths, derived register count and data/index types
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int DEF_DATA_W   = 8;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_NUM_REGS = 2 ** DEF_ADDR_W;

  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] idx_t;

endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// ----------------------------------------------------------------------------
// regfile_read_port : NUM_REGS:1 read mux with optional write-through forward
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
  input  logic [ADDR_W-1:0]                  idx,
  output logic [DATA_W-1:0]                  data
`ifdef REGFILE_BYPASS_EN
  ,
  input  logic                               wr_en,
  input  logic [ADDR_W-1:0]                  wr_idx,
  input  logic [DATA_W-1:0]                  wr_data
`endif
);

`ifdef REGFILE_BYPASS_EN
  // Forward the pending write so the reader sees it in the same cycle.
  always_comb begin
    data = regs[idx];
    if (wr_en && (wr_idx == idx)) begin
      data = wr_data;
    end
  end
`else
  always_comb begin
    data = regs[idx];
  end
`endif

endmodule

`default_nettype wire

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file : 2R/1W register file; define REGFILE_BYPASS_EN for forwarding
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg_read_1,
  input  logic [ADDR_W-1:0] reg_read_2,
  input  logic [ADDR_W-1:0] reg_write,
  input  logic              read_write,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data_1,
  output logic [DATA_W-1:0] out_data_2
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  // Reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else if (read_write) begin
      regs[reg_write] <= in_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_en;
  assign wr_en = read_write & ~rst;
`endif

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_1 (
    .regs    (regs),
    .idx     (reg_read_1),
    .data    (out_data_1)
`ifdef REGFILE_BYPASS_EN
    ,
    .wr_en   (wr_en),
    .wr_idx  (reg_write),
    .wr_data (in_data)
`endif
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_read_2 (
    .regs    (regs),
    .idx     (reg_read_2),
    .data    (out_data_2)
`ifdef REGFILE_BYPASS_EN
    ,
    .wr_en   (wr_en),
    .wr_idx  (reg_write),
    .wr_data (in_data)
`endif
  );

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file : directed vectors, expected reads queued and checked at negedge
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_register_file;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] reg_read_1;
  logic [2:0] reg_read_2;
  logic [2:0] reg_write;
  logic       read_write;
  logic [7:0] in_data;
  logic [7:0] out_data_1;
  logic [7:0] out_data_2;

  typedef struct packed {
    logic [7:0]  e1;
    logic [7:0]  e2;
    logic [95:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  register_file dut (
    .clk        (clk),
    .rst        (rst),
    .reg_read_1 (reg_read_1),
    .reg_read_2 (reg_read_2),
    .reg_write  (reg_write),
    .read_write (read_write),
    .in_data    (in_data),
    .out_data_1 (out_data_1),
    .out_data_2 (out_data_2)
  );

  always #5 clk = ~clk;

  // Monitor: consume one expected pair per cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (out_data_1 !== e.e1) begin
        errors = errors + 1;
        $display("FAIL %0s port1: got %02h expected %02h", e.tag, out_data_1, e.e1);
      end
      checks = checks + 1;
      if (out_data_2 !== e.e2) begin
        errors = errors + 1;
        $display("FAIL %0s port2: got %02h expected %02h", e.tag, out_data_2, e.e2);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input logic [2:0] r1, input logic [2:0] r2,
                           input logic [7:0] e1, input logic [7:0] e2,
                           input logic [95:0] tag);
    exp_t e;
    reg_read_1 = r1;
    reg_read_2 = r2;
    e.e1  = e1;
    e.e2  = e2;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic do_write(input logic [2:0] idx, input logic [7:0] d);
    read_write = 1'b1;
    reg_write  = idx;
    in_data    = d;
    cyc();
    read_write = 1'b0;
  endtask

  initial begin
    int wait_cnt;
    rst        = 1'b1;
    reg_read_1 = '0;
    reg_read_2 = '0;
    reg_write  = 3'd0;
    read_write = 1'b1;
    in_data    = 8'h33;
    cyc();
    cyc();
    rst        = 1'b0;
    read_write = 1'b0;

    for (int i = 0; i < 8; i++) begin
      expect_rd(3'(i), 3'(7 - i), 8'h00, 8'h00, "reset");
      cyc();
    end

    do_write(3'd5, 8'h5B);
    do_write(3'd3, 8'hC5);
    expect_rd(3'd5, 3'd3, 8'h5B, 8'hC5, "wr_rd");
    cyc();

    read_write = 1'b0;
    reg_write  = 3'd5;
    in_data    = 8'hFF;
    cyc();
    expect_rd(3'd5, 3'd5, 8'h5B, 8'h5B, "wr_dis");
    cyc();

    expect_rd(3'd3, 3'd3, 8'hC5, 8'hC5, "same_idx");
    cyc();
    do_write(3'd3, 8'h11);
    expect_rd(3'd3, 3'd3, 8'h11, 8'h11, "same_idx_wr");
    cyc();

    do_write(3'd2, 8'h22);
    expect_rd(3'd2, 3'd5, 8'h22, 8'h5B, "pre_rst");
    cyc();
    rst        = 1'b1;
    read_write = 1'b1;
    reg_write  = 3'd2;
    in_data    = 8'hAA;
    cyc();
    rst        = 1'b0;
    read_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      expect_rd(3'(i), 3'd2, 8'h00, 8'h00, "rst_vs_wr");
      cyc();
    end

    // Pending write to r4 observed before its commit edge.
    read_write = 1'b1;
    reg_write  = 3'd4;
    in_data    = 8'h77;
    expect_rd(3'd4, 3'd4, BYPASS ? 8'h77 : 8'h00, BYPASS ? 8'h77 : 8'h00, "bypass");
    cyc();
    read_write = 1'b0;
    expect_rd(3'd4, 3'd0, 8'h77, 8'h00, "post_bypass");
    cyc();

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      cyc();
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors = errors + 1;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
